// File: rtl/logic_unit_arbiter_if.sv
// logic_unit_arbiter_if: requester operand bus and result bus of the shared logic unit arbiter
interface logic_unit_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 8
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] a_in;
    logic [N_REQ-1:0] b_in;
    logic [N_REQ-1:0] c_in;
    logic [N_REQ-1:0] gnt;
    logic             busy;
    logic             valid_out;
    logic             y_out;
    logic [ID_W-1:0]  id_out;
    logic [CNT_W-1:0] done_cnt;
    modport master (output req, a_in, b_in, c_in, input gnt, busy, valid_out, y_out, id_out, done_cnt);
    modport slave  (input req, a_in, b_in, c_in, output gnt, busy, valid_out, y_out, id_out, done_cnt);
endinterface

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin sharing of one two-stage registered y = (a & b) | c unit
module logic_unit_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 8
) (
    input logic                clk,
    input logic                rst_n,
    logic_unit_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, STAGE1, STAGE2} state_t;
    state_t           state, state_d;
    logic [ID_W-1:0]  ptr, w, id, id_q;
    logic [ID_W:0]    sum;
    logic [N_REQ-1:0] rot, oh, gnt;
    logic             hit, arb, op_a, op_b, op_c, s, valid, y;
    logic [CNT_W-1:0] cnt;
    // Rotate so bit 0 is the requester at ptr; the lowest set rotated bit wins.
    always_comb begin
        rot = N_REQ'({bus.req, bus.req} >> ptr);
        hit = 1'b0;
        sum = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, ptr} + (ID_W+1)'(k);
                hit = 1'b1;
            end
        end
        w = sum >= (ID_W+1)'(N_REQ) ? ID_W'(sum - (ID_W+1)'(N_REQ)) : ID_W'(sum);
        oh = N_REQ'(1) << w;
        arb = state == IDLE && hit;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end
    always_comb begin
        state_d = state == IDLE ? (hit ? STAGE1 : IDLE) : state == STAGE1 ? STAGE2 : IDLE;
    end
    always_comb begin
        bus.busy = state != IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            gnt   <= '0;
            op_a  <= 1'b0;
            op_b  <= 1'b0;
            op_c  <= 1'b0;
            id    <= '0;
            s     <= 1'b0;
            valid <= 1'b0;
            y     <= 1'b0;
            id_q  <= '0;
            cnt   <= '0;
        end else begin
            gnt   <= arb ? oh : '0;
            valid <= state == STAGE2;
            if (arb) begin
                op_a <= |(bus.a_in & oh);
                op_b <= |(bus.b_in & oh);
                op_c <= |(bus.c_in & oh);
                id   <= w;
                ptr  <= w == ID_W'(N_REQ - 1) ? '0 : w + ID_W'(1);
            end
            if (state == STAGE1) s <= op_a & op_b;
            if (state == STAGE2) begin
                y    <= s | op_c;
                id_q <= id;
                cnt  <= cnt + CNT_W'(1);
            end
        end
    end
    assign bus.gnt       = gnt;
    assign bus.valid_out = valid;
    assign bus.y_out     = y;
    assign bus.id_out    = id_q;
    assign bus.done_cnt  = cnt;
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: directed vector table plus hand-written multi-cycle sequences
module tb_logic_unit_arbiter;
    typedef struct {
        logic [3:0] req, a, b, c;
        int         id;
        logic       y;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[9];
    logic_unit_arbiter_if #(.N_REQ(4), .ID_W(2), .CNT_W(8)) bus ();
    logic_unit_arbiter #(.N_REQ(4), .ID_W(2), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_valid(input string name);
        for (int t = 0; t < 10; t++) begin
            tick();
            if (bus.valid_out === 1'b1) return;
        end
        check({name, "_timeout"}, 0, 1);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        // operands of non-winners disagree with the winner so a wrong select shows up in y
        vecs[0] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 2, 1'b1};
        vecs[1] = '{4'b0100, 4'b1111, 4'b1011, 4'b1011, 2, 1'b0};
        vecs[2] = '{4'b0100, 4'b1011, 4'b0000, 4'b0100, 2, 1'b1};
        vecs[3] = '{4'b1001, 4'b1000, 4'b1000, 4'b0000, 3, 1'b1};
        vecs[4] = '{4'b1001, 4'b1111, 4'b1110, 4'b1110, 0, 1'b0};
        vecs[5] = '{4'b0011, 4'b0000, 4'b0000, 4'b0010, 1, 1'b1};
        vecs[6] = '{4'b0011, 4'b0001, 4'b0001, 4'b0000, 0, 1'b1};
        vecs[7] = '{4'b1010, 4'b1111, 4'b1101, 4'b1101, 1, 1'b0};
        vecs[8] = '{4'b1010, 4'b0111, 4'b0111, 4'b1000, 3, 1'b1};
        bus.req = 4'b1111;
        bus.a_in = 4'b1111;
        bus.b_in = 4'b1111;
        bus.c_in = 4'b1111;
        repeat (3) tick();
        check("rst_gnt", bus.gnt, 0);
        check("rst_valid", bus.valid_out, 0);
        check("rst_y", bus.y_out, 0);
        check("rst_id", bus.id_out, 0);
        check("rst_cnt", bus.done_cnt, 0);
        check("rst_busy", bus.busy, 0);
        @(negedge clk);
        bus.req = '0;
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.req = vecs[i].req;
            bus.a_in = vecs[i].a;
            bus.b_in = vecs[i].b;
            bus.c_in = vecs[i].c;
            tick();
            check($sformatf("v%0d_gnt", i), bus.gnt, 32'(1) << vecs[i].id);
            check($sformatf("v%0d_busy", i), bus.busy, 1);
            bus.req = '0;
            bus.a_in = ~vecs[i].a;
            bus.b_in = ~vecs[i].b;
            bus.c_in = ~vecs[i].c;
            tick();
            check($sformatf("v%0d_gnt_off", i), bus.gnt, 0);
            check($sformatf("v%0d_early_valid", i), bus.valid_out, 0);
            tick();
            check($sformatf("v%0d_valid", i), bus.valid_out, 1);
            check($sformatf("v%0d_y", i), bus.y_out, vecs[i].y);
            check($sformatf("v%0d_id", i), bus.id_out, vecs[i].id);
            check($sformatf("v%0d_cnt", i), bus.done_cnt, i + 1);
            tick();
            check($sformatf("v%0d_valid_off", i), bus.valid_out, 0);
            check($sformatf("v%0d_y_hold", i), bus.y_out, vecs[i].y);
            check($sformatf("v%0d_idle", i), bus.busy, 0);
        end
        // fairness: all four requesting continuously, results 3 cycles apart
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.req = 4'b1111;
        bus.a_in = 4'b1111;
        bus.b_in = 4'b0101;
        bus.c_in = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("rr%0d_gnt", i), bus.gnt, 32'(1) << (i % 4));
            tick();
            check($sformatf("rr%0d_gnt_off", i), bus.gnt, 0);
            tick();
            check($sformatf("rr%0d_valid", i), bus.valid_out, 1);
            check($sformatf("rr%0d_id", i), bus.id_out, i % 4);
            check($sformatf("rr%0d_y", i), bus.y_out, (i % 2) == 0);
            check($sformatf("rr%0d_cnt", i), bus.done_cnt, i + 1);
        end
        @(negedge clk);
        bus.req = '0;
        tick();
        check("rr_final_cnt", bus.done_cnt, 6);
        check("rr_final_gnt", bus.gnt, 0);
        // ptr is now 2: requester 3 wins, then reset lands while in STAGE1
        @(negedge clk);
        bus.req = 4'b1010;
        tick();
        check("ab_gnt", bus.gnt, 4'b1000);
        check("ab_busy", bus.busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ab_busy_clr", bus.busy, 0);
        check("ab_gnt_clr", bus.gnt, 0);
        check("ab_cnt_clr", bus.done_cnt, 0);
        repeat (3) begin
            tick();
            check("ab_no_valid", bus.valid_out, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("ab_next_gnt", bus.gnt, 4'b0010);
        tick();
        tick();
        check("ab_next_valid", bus.valid_out, 1);
        check("ab_next_id", bus.id_out, 1);
        check("ab_next_cnt", bus.done_cnt, 1);
        // counter wrap: single requester wins every arbitration
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.req = 4'b0001;
        for (int n = 1; n <= 256; n++) begin
            wait_valid($sformatf("wrap%0d", n));
            check($sformatf("wrap%0d_cnt", n), bus.done_cnt, n % 256);
            check($sformatf("wrap%0d_id", n), bus.id_out, 0);
        end
        @(negedge clk);
        bus.req = '0;
        tick();
        check("wrap_final_cnt", bus.done_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
